// File: rtl/stop_watch_lap_timer.sv
// Stopwatch with run/pause/clear control, a MAX->0 wrap pulse and a
// first-word-fall-through FIFO that buffers lap times for a downstream reader.
module stop_watch_lap_timer #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX        = 99,
    parameter int LAP_DEPTH  = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               stop,
    input  logic                               clear,
    input  logic                               lap,
    input  logic                               lap_rd,
    output logic [DATA_WIDTH-1:0]              count,
    output logic                               running,
    output logic                               wrap,
    output logic [DATA_WIDTH-1:0]              lap_data,
    output logic                               lap_valid,
    output logic [$clog2(LAP_DEPTH+1)-1:0]     lap_count,
    output logic                               lap_overflow
);

    localparam int PW = $clog2(LAP_DEPTH);
    localparam int CW = $clog2(LAP_DEPTH+1);
    localparam logic [DATA_WIDTH-1:0] MAX_VAL    = DATA_WIDTH'(MAX);
    localparam logic [CW-1:0]         FULL_COUNT = CW'(LAP_DEPTH);

    typedef enum logic {
        PAUSED  = 1'b0,
        RUNNING = 1'b1
    } run_state_t;

    run_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic                  wrap_q, wrap_d;
    logic                  advance;

    logic [DATA_WIDTH-1:0] lap_mem [LAP_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         lap_count_q;
    logic                  overflow_q;
    logic                  fifo_empty, fifo_full;
    logic                  do_push, do_pop, drop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= PAUSED;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    // Priority clear > stop > start > free-running; a start cycle always counts.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        advance = 1'b0;
        if (clear) begin
            state_d = PAUSED;
        end else if (stop) begin
            state_d = PAUSED;
        end else if (start) begin
            state_d = RUNNING;
            advance = 1'b1;
        end else if (state_q == RUNNING) begin
            advance = 1'b1;
        end
        if (clear) begin
            count_d = '0;
        end else if (advance) begin
            count_d = (count_q == MAX_VAL) ? '0 : count_q + 1'b1;
        end
        wrap_d = advance && (count_q == MAX_VAL);
    end

    assign fifo_empty = (lap_count_q == '0);
    assign fifo_full  = (lap_count_q == FULL_COUNT);
    assign do_pop     = lap_rd && !fifo_empty;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    assign do_push    = lap && (!fifo_full || do_pop);
    assign drop       = lap && fifo_full && !do_pop;

    always_ff @(posedge clk) begin
        if (do_push) begin
            lap_mem[wr_ptr_q] <= count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            lap_count_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   lap_count_q <= lap_count_q + 1'b1;
                2'b01:   lap_count_q <= lap_count_q - 1'b1;
                default: lap_count_q <= lap_count_q;
            endcase
            if (clear) begin
                overflow_q <= 1'b0;
            end else if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign count        = count_q;
    assign running      = (state_q == RUNNING);
    assign wrap         = wrap_q;
    assign lap_data     = lap_mem[rd_ptr_q];
    assign lap_valid    = !fifo_empty;
    assign lap_count    = lap_count_q;
    assign lap_overflow = overflow_q;

endmodule
